// File: rtl/activity_display_scheduler.sv
// Rotates four activity metrics through one shared BCD converter onto the display.
// Optional macro SKIP_ZERO_EN: rotation skips metrics whose value is zero.
module activity_display_scheduler #(
    parameter int TICK_CYCLES = 100000000,
    parameter int DWELL_SEC   = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] metric0,
    input  logic [15:0] metric1,
    input  logic [15:0] metric2,
    input  logic [15:0] metric3,
    input  logic        hold,
    output logic        conv_req,
    output logic [15:0] conv_bin,
    input  logic        conv_ack,
    input  logic [19:0] conv_bcd,
    output logic [19:0] disp_bcd,
    output logic [1:0]  disp_sel,
    output logic        disp_valid,
    output logic        disp_err
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DWELL_SEC + 2);
    localparam int OW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DWELL
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [DW-1:0] r_dwell_cnt;
    logic [OW-1:0] r_wait_cnt;
    logic [1:0]    r_idx;
    logic          r_conv_req;
    logic [15:0]   r_conv_bin;
    logic [19:0]   r_disp_bcd;
    logic [1:0]    r_disp_sel;
    logic          r_disp_valid;
    logic          r_disp_err;

    logic          w_tick;
    logic          w_ack;
    logic          w_timeout;
    logic          w_rotate;
    logic [DW-1:0] w_dwell_inc;
    logic [1:0]    w_next_idx;
    logic [15:0]   w_metric [4];

    assign w_metric[0] = metric0;
    assign w_metric[1] = metric1;
    assign w_metric[2] = metric2;
    assign w_metric[3] = metric3;

    assign w_tick      = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_ack       = (r_state == S_WAIT) && conv_ack;
    assign w_timeout   = (r_state == S_WAIT) && !conv_ack &&
                         (r_wait_cnt == OW'(TIMEOUT - 1));
    assign w_dwell_inc = r_dwell_cnt + DW'(1);
    assign w_rotate    = (r_state == S_DWELL) && w_tick && !hold &&
                         (w_dwell_inc >= DW'(DWELL_SEC));

`ifdef SKIP_ZERO_EN
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic [1:0] w_cand3;

    assign w_cand1 = r_idx + 2'd1;
    assign w_cand2 = r_idx + 2'd2;
    assign w_cand3 = r_idx + 2'd3;

    // First nonzero metric after the current one; stay put if none.
    always_comb begin
        w_next_idx = r_idx;
        if (w_metric[w_cand1] != 16'd0)
            w_next_idx = w_cand1;
        else if (w_metric[w_cand2] != 16'd0)
            w_next_idx = w_cand2;
        else if (w_metric[w_cand3] != 16'd0)
            w_next_idx = w_cand3;
    end
`else
    assign w_next_idx = r_idx + 2'd1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Ticks outside DWELL are dropped, so ack/timeout win over a same-cycle tick.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_ack || w_timeout) w_state_nxt = S_DWELL;
            S_DWELL: if (w_tick) w_state_nxt = S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= 2'd0;
            r_dwell_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_conv_req   <= 1'b0;
            r_conv_bin   <= 16'd0;
            r_disp_bcd   <= 20'd0;
            r_disp_sel   <= 2'd0;
            r_disp_valid <= 1'b0;
            r_disp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_idx <= 2'd0;
                end
                S_REQ: begin
                    r_conv_bin <= w_metric[r_idx];
                    r_conv_req <= 1'b1;
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (conv_ack) begin
                        r_disp_bcd   <= conv_bcd;
                        r_disp_sel   <= r_idx;
                        r_disp_valid <= 1'b1;
                        r_disp_err   <= 1'b0;
                        r_conv_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_disp_bcd   <= 20'hFFFFF;
                        r_disp_valid <= 1'b0;
                        r_disp_err   <= 1'b1;
                        r_conv_req   <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + OW'(1);
                    end
                end
                S_DWELL: begin
                    if (w_rotate) begin
                        r_idx       <= w_next_idx;
                        r_dwell_cnt <= '0;
                    end else if (w_tick) begin
                        // Saturate so release after a long hold rotates at once.
                        if (w_dwell_inc > DW'(DWELL_SEC))
                            r_dwell_cnt <= DW'(DWELL_SEC);
                        else
                            r_dwell_cnt <= w_dwell_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv_req   = r_conv_req;
    assign conv_bin   = r_conv_bin;
    assign disp_bcd   = r_disp_bcd;
    assign disp_sel   = r_disp_sel;
    assign disp_valid = r_disp_valid;
    assign disp_err   = r_disp_err;

endmodule

// File: tb/tb_activity_display_scheduler.sv
// Bench for activity_display_scheduler: table of first conversions, corner
// sequences (tick collisions, timeout, hold, reset mid-wait) and a random run.
module tb_activity_display_scheduler;

    localparam int TICK  = 10;
    localparam int DWELL = 2;
    localparam int TOUT  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mv [4];
    logic        hold = 1'b0;
    logic        conv_req;
    logic [15:0] conv_bin;
    logic        conv_ack = 1'b0;
    logic [19:0] conv_bcd = 20'd0;
    logic [19:0] disp_bcd;
    logic [1:0]  disp_sel;
    logic        disp_valid;
    logic        disp_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_lat = 0;
    bit ack_en = 1'b1;
    bit spur_en = 1'b0;
    int req_age = 0;

    activity_display_scheduler #(
        .TICK_CYCLES(TICK),
        .DWELL_SEC(DWELL),
        .TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .metric0(mv[0]),
        .metric1(mv[1]),
        .metric2(mv[2]),
        .metric3(mv[3]),
        .hold(hold),
        .conv_req(conv_req),
        .conv_bin(conv_bin),
        .conv_ack(conv_ack),
        .conv_bcd(conv_bcd),
        .disp_bcd(disp_bcd),
        .disp_sel(disp_sel),
        .disp_valid(disp_valid),
        .disp_err(disp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        logic [19:0] r;
        int n;
        r = '0;
        n = int'(v);
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic int advance(input int idx);
`ifdef SKIP_ZERO_EN
        for (int s = 1; s < 4; s++)
            if (mv[(idx + s) % 4] != 16'd0) return (idx + s) % 4;
        return idx;
`else
        return (idx + 1) % 4;
`endif
    endfunction

    // Converter model: acks ack_lat cycles into a request; random acks while idle.
    always @(negedge clk) begin
        if (conv_req) begin
            conv_ack = ack_en && (req_age == ack_lat);
            conv_bcd = conv_ack ? to_bcd(conv_bin) : 20'd0;
            req_age++;
        end else begin
            req_age = 0;
            conv_ack = spur_en && ($urandom_range(0, 2) == 0);
            conv_bcd = 20'($urandom());
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_rst(input string nm);
        check({nm, " conv_req"}, 32'(conv_req), 32'd0);
        check({nm, " conv_bin"}, 32'(conv_bin), 32'd0);
        check({nm, " disp_bcd"}, 32'(disp_bcd), 32'd0);
        check({nm, " disp_sel"}, 32'(disp_sel), 32'd0);
        check({nm, " disp_valid"}, 32'(disp_valid), 32'd0);
        check({nm, " disp_err"}, 32'(disp_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One request/response: negedges waited, cycle of rise, cycles held high.
    task automatic conv(input string nm, output logic [15:0] bin,
                        output int rise, output int high, output int wt);
        wt = 0;
        while (!conv_req && wt < 80) begin
            @(negedge clk);
            wt++;
        end
        check({nm, " req rise"}, 32'(conv_req), 32'd1);
        bin = conv_bin;
        rise = cyc;
        high = 0;
        while (conv_req && high < 80) begin
            @(negedge clk);
            high++;
        end
        check({nm, " req fall"}, 32'(conv_req), 32'd0);
    endtask

    typedef struct {
        logic [15:0] m0;
        int          lat;
        logic [19:0] bcd;
    } vec_t;

    vec_t        tbl [5];
    logic [15:0] bin;
    int          rise;
    int          prev;
    int          high;
    int          wt;
    int          idx;

    initial begin
        tbl[0] = '{16'd1234, 2, 20'h01234};
        tbl[1] = '{16'd0, 0, 20'h00000};
        tbl[2] = '{16'd65535, 4, 20'h65535};
        tbl[3] = '{16'd9, 1, 20'h00009};
        tbl[4] = '{16'd10000, 3, 20'h10000};
        mv = '{16'd0, 16'd0, 16'd0, 16'd0};

        #3;
        check_rst("por");

        for (int i = 0; i < 5; i++) begin
            mv = '{tbl[i].m0, 16'd11, 16'd22, 16'd33};
            ack_lat = tbl[i].lat;
            do_reset();
            conv($sformatf("vec%0d", i), bin, rise, high, wt);
            check($sformatf("vec%0d edges to req", i), wt, 2);
            check($sformatf("vec%0d conv_bin", i), 32'(bin), 32'(tbl[i].m0));
            check($sformatf("vec%0d req cycles", i), high, tbl[i].lat + 1);
            check($sformatf("vec%0d disp_bcd", i), 32'(disp_bcd), 32'(tbl[i].bcd));
            check($sformatf("vec%0d disp_sel", i), 32'(disp_sel), 32'd0);
            check($sformatf("vec%0d valid", i), 32'(disp_valid), 32'd1);
            check($sformatf("vec%0d err", i), 32'(disp_err), 32'd0);
        end

        // Ack lands on the tick edge: that tick is lost.
        mv = '{16'd42, 16'd1, 16'd2, 16'd3};
        ack_lat = 7;
        do_reset();
        conv("coinc0", bin, prev, high, wt);
        check("coinc req cycles", high, 8);
        ack_lat = 1;
        conv("coinc1", bin, rise, high, wt);
        check("coinc gap", rise - prev, 2 * TICK - 1);
        check("coinc sel", 32'(disp_sel), 32'd0);
        check("coinc bcd", 32'(disp_bcd), 32'h00042);

        // Timeout expiring on the tick edge.
        ack_en = 1'b0;
        do_reset();
        conv("tout", bin, prev, high, wt);
        check("tout req cycles", high, TOUT);
        check("tout bcd", 32'(disp_bcd), 32'hFFFFF);
        check("tout err", 32'(disp_err), 32'd1);
        check("tout valid", 32'(disp_valid), 32'd0);
        ack_en = 1'b1;
        conv("tout next", bin, rise, high, wt);
        check("tout gap", rise - prev, 2 * TICK - 1);
        check("tout err clr", 32'(disp_err), 32'd0);
        check("tout valid set", 32'(disp_valid), 32'd1);
        check("tout next bcd", 32'(disp_bcd), 32'h00042);

        // Hold freezes rotation on metric 1 for five refreshes.
        mv = '{16'd1, 16'd2, 16'd3, 16'd4};
        do_reset();
        for (int k = 0; k < 3; k++) conv("hold pre", bin, rise, high, wt);
        check("hold pre sel", 32'(disp_sel), 32'd1);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            conv("hold", bin, rise, high, wt);
            check($sformatf("hold bin %0d", k), 32'(bin), 32'd2);
            check($sformatf("hold sel %0d", k), 32'(disp_sel), 32'd1);
        end
        hold = 1'b0;
        conv("hold rel", bin, rise, high, wt);
        check("hold rel bin", 32'(bin), 32'd3);
        check("hold rel sel", 32'(disp_sel), 32'd2);

        // Reset two cycles into a wait clears everything at once.
        mv = '{16'd1234, 16'd5, 16'd6, 16'd7};
        ack_lat = 2;
        do_reset();
        conv("mid pre", bin, rise, high, wt);
        check("mid pre bcd", 32'(disp_bcd), 32'h01234);
        ack_en = 1'b0;
        wt = 0;
        while (!conv_req && wt < 80) begin
            @(negedge clk);
            wt++;
        end
        check("mid req", 32'(conv_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_rst("mid");
        @(negedge clk);
        reset = 1'b1;
        ack_en = 1'b1;
        conv("mid restart", bin, rise, high, wt);
        check("mid restart edges", wt, 2);
        check("mid restart bcd", 32'(disp_bcd), 32'h01234);
        check("mid restart sel", 32'(disp_sel), 32'd0);

        // Zero-valued metrics, then all zero.
        for (int p = 0; p < 2; p++) begin
            if (p == 0) mv = '{16'd5, 16'd0, 16'd0, 16'd7};
            else mv = '{16'd0, 16'd0, 16'd0, 16'd0};
            ack_lat = 0;
            do_reset();
            idx = 0;
            for (int k = 0; k < 7; k++) begin
                if (k > 0 && k % DWELL == 0) idx = advance(idx);
                conv("zero", bin, rise, high, wt);
                check($sformatf("zero%0d sel %0d", p, k), 32'(disp_sel), 32'(idx));
                check($sformatf("zero%0d bcd %0d", p, k), 32'(disp_bcd),
                      32'(to_bcd(mv[idx])));
            end
        end

        // Random metrics, latencies and stray acks against the model.
        spur_en = 1'b1;
        mv = '{16'd100, 16'd200, 16'd300, 16'd400};
        do_reset();
        idx = 0;
        prev = 0;
        for (int k = 0; k < 30; k++) begin
            ack_lat = $urandom_range(0, 4);
            if (k > 0 && k % DWELL == 0) idx = advance(idx);
            conv("rnd", bin, rise, high, wt);
            check($sformatf("rnd bin %0d", k), 32'(bin), 32'(mv[idx]));
            check($sformatf("rnd sel %0d", k), 32'(disp_sel), 32'(idx));
            check($sformatf("rnd bcd %0d", k), 32'(disp_bcd), 32'(to_bcd(mv[idx])));
            check($sformatf("rnd lat %0d", k), high, ack_lat + 1);
            check($sformatf("rnd valid %0d", k), 32'(disp_valid), 32'd1);
            if (k == 1) check("rnd gap first", rise - prev, TICK - 1);
            if (k > 1) check($sformatf("rnd gap %0d", k), rise - prev, TICK);
            prev = rise;
            for (int j = 0; j < 4; j++)
                mv[j] = ($urandom_range(0, 3) == 0) ? 16'd0 :
                        16'($urandom_range(1, 65535));
        end
        spur_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/activity_display_scheduler.md
# activity_display_scheduler

Time-multiplexes the four activity metrics (step count, distance, high-activity minutes, seconds over 32 steps/s) onto the single watch display. Shares one binary-to-BCD converter through a req/ack handshake, rotates the displayed metric every DWELL_SEC seconds and refreshes the shown value once per second. Sits between the metric counters and the seven-segment driver.

## Interface

Parameters:
- TICK_CYCLES, 100000000: clk cycles per one-second tick.
- DWELL_SEC, 2: seconds each metric stays on the display.
- TIMEOUT, 64: clk cycles to wait for conv_ack before flagging an error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- metric0  in  16  step count.
- metric1  in  16  distance, in tenths of a mile.
- metric2  in  16  high-activity minutes, zero-extended.
- metric3  in  16  seconds over 32 steps/s.
- hold  in  1  freezes rotation on the current metric while high.
- conv_req  out  1  conversion request to the shared BCD converter.
- conv_bin  out  16  binary operand; stable while conv_req is high.
- conv_ack  in  1  converter done; conv_bcd valid in the same cycle.
- conv_bcd  in  20  five BCD digits.
- disp_bcd  out  20  digits currently displayed.
- disp_sel  out  2  index of the displayed metric.
- disp_valid  out  1  disp_bcd holds a completed conversion.
- disp_err  out  1  last conversion timed out.

## Operation

- Tick generator:
  - Counter runs 0..TICK_CYCLES-1.
  - One-cycle `tick` pulses when the count equals TICK_CYCLES-1, then the count wraps to 0.
  - Free-running, independent of the FSM.
- FSM states are IDLE, REQ, WAIT, DWELL.
- IDLE:
  - Entered on reset.
  - Moves to REQ on the next clk edge with idx=0.
- REQ:
  - Captures metric[idx] into conv_bin.
  - Asserts conv_req.
  - Moves to WAIT.
- WAIT:
  - conv_req stays high and conv_bin is held stable.
  - On conv_ack=1:
    - latch conv_bcd into disp_bcd;
    - disp_sel<=idx, disp_valid<=1, disp_err<=0;
    - drop conv_req on the same edge;
    - go to DWELL.
  - If TIMEOUT cycles pass in WAIT with no ack:
    - disp_bcd<=20'hFFFFF, disp_err<=1, disp_valid<=0;
    - drop conv_req and go to DWELL.
- DWELL:
  - On each tick, dwell_cnt increments.
  - If dwell_cnt reaches DWELL_SEC and hold=0: idx<=idx+1 (mod 4, 3 wraps to 0), dwell_cnt<=0, go to REQ.
  - Otherwise, on tick: same idx, go to REQ. This is the once-per-second live refresh.
  - While hold=1, dwell_cnt saturates at DWELL_SEC. Rotation happens on the first tick after hold falls.
- A conv_ack that arrives outside WAIT is ignored.
- Metric inputs are sampled only in REQ. Later changes take effect at the next refresh.
- Reset mid-handshake: conv_req falls immediately (asynchronously) and the FSM returns to IDLE. The converter must tolerate a dropped request.

## Timing

- Reset values:
  - conv_req=0, conv_bin=0;
  - disp_bcd=0, disp_sel=0, disp_valid=0, disp_err=0;
  - idx=0, dwell_cnt=0, tick counter=0.
- Edges after reset deassertion:
  - IDLE->REQ on the first edge.
  - conv_req is high after the second edge.
- Ack latency: disp_bcd updates on the edge that samples conv_ack=1.
  - conv_req is low from that edge on.
  - Minimum request-to-display latency is 2 cycles after REQ.
- Timeout: conv_req is high for exactly TIMEOUT cycles, then drops.
- Coincident events:
  - tick and conv_ack in the same cycle: ack wins. The tick is dropped and the refresh waits for the next tick.
  - tick and the timeout expiry in the same cycle: timeout wins. The tick is dropped.

## Configuration

- SKIP_ZERO_EN:
  - Defined: when advancing, idx moves to the next metric whose value is nonzero at that moment. The search examines up to three candidates in one cycle.
  - If all other metrics are zero, idx stays unchanged.
  - Refreshes of the current idx are never skipped.
  - Undefined: strict 0,1,2,3 rotation regardless of value.

## Test plan

- Reset/first conversion: TICK_CYCLES=10, DWELL_SEC=2, metric0=1234, converter acks 3 cycles after req with 20'h01234 -> disp_bcd=20'h01234, disp_sel=0, disp_valid=1, conv_req low after ack.
- Rotation: metrics 1,2,3,4, ack always -> disp_sel sequence 0,0,1,1,2,2,3,3,0 at one change per tick. The index changes every 2 ticks.
- Hold: assert hold while disp_sel=1 for 5 ticks -> disp_sel stays 1 with 5 refresh requests. On release, disp_sel=2 at the next tick.
- Timeout: TIMEOUT=8, never ack -> conv_req high exactly 8 cycles, disp_bcd=20'hFFFFF, disp_err=1, disp_valid=0. The next successful ack clears disp_err.
- Reset mid-WAIT: pull reset low 2 cycles after conv_req rises -> conv_req=0 and all outputs return to reset values asynchronously. Restart then follows the first scenario.
- SKIP_ZERO_EN defined, metrics 5,0,0,7 -> disp_sel alternates 0,3,0,3. With all metrics 0, disp_sel stays 0.
